ram_banked_be: RTL
==================

Name: ram_banked_be

Overview:
- Parametrised single-port synchronous RAM built from LANE_W-wide byte lanes.
- Generalises the fixed 4x16 two-slice RAM to arbitrary width and depth, and adds:
  - per-lane write enables
  - a registered read with a valid strobe
  - a sequenced zero-fill (init) engine with a busy flag
  - out-of-range address detection
- Sits between the datapath/controller and any register-file or scratch-memory user in the guide designs.

Parameters:
- LANE_W, 8: width of one lane (byte) in bits.
- LANES, 2: number of lanes. DATA_W = LANE_W*LANES.
- ADDR_W, 3: address width in bits.
- DEPTH, 4: number of implemented words; 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- clr  in  1  synchronous reset, active-low.
- en  in  1  access request; sampled only when busy=0.
- rw  in  1  1 = write, 0 = read.
- be  in  LANES  lane write enables; ignored on reads.
- addr  in  ADDR_W  word address.
- data_in  in  LANE_W*LANES  write data; lane k = data_in[k*LANE_W +: LANE_W].
- init  in  1  request zero-fill of all DEPTH words.
- data_out  out  LANE_W*LANES  registered read data.
- rd_valid  out  1  one-cycle pulse: data_out updated this cycle.
- busy  out  1  zero-fill in progress; accesses ignored.
- err  out  1  one-cycle pulse: last accepted access had addr >= DEPTH.

Behaviour:
- Reset (clr=0 at an edge):
  - data_out=0, rd_valid=0, err=0, busy=1.
  - FSM enters FILL with fill pointer = 0.
  - Memory array is not cleared in that cycle; the array is cleared by the FILL sequence.
- FSM states:
  - IDLE: accepts accesses. init=1 -> FILL with pointer 0 and busy=1 from the next cycle; any access in the same cycle as init is ignored.
  - FILL: each cycle writes 0 to word[pointer], then pointer++.
  - When the pointer reaches DEPTH-1, that word is written, and the next state is IDLE with busy=0.
  - Fill takes exactly DEPTH cycles after reset release or after the init-accept edge.
- Accesses in FILL:
  - en is ignored; no write, rd_valid=0, err=0.
  - init in FILL is ignored, with no restart.
- Write (IDLE, en=1, rw=1, addr<DEPTH):
  - For each k with be[k]=1, word[addr] lane k <= data_in lane k.
  - Other lanes are unchanged.
  - be=0 is a legal no-op.
  - data_out is unchanged and rd_valid=0.
- Read (IDLE, en=1, rw=0, addr<DEPTH): at the next edge, data_out <= word[addr] and rd_valid=1 for exactly one cycle.
  - Latency 1: request at edge N, data visible after edge N.
  - data_out holds its value until the next read or reset.
- Back-to-back reads: each read gives one pulse; rd_valid stays high on consecutive read cycles.
- Write then read of the same address on the next cycle returns the newly written data (no bypass is needed, since accesses are sequential).
- Out of range (addr >= DEPTH, IDLE, en=1):
  - Write: suppressed.
  - Read: data_out <= 0 and rd_valid=1.
  - Both cases: err=1 for one cycle.
- en=0 in IDLE: rd_valid=0 and err=0.
- Reset mid-fill or mid-access: clr=0 takes priority over everything and restarts the fill from 0.
- Pointer width is ADDR_W. No wrap is possible because the pointer stops at DEPTH-1.

Test Plan:
- Reset and fill:
  - Stimulus: clr=0 for 2 cycles, then release.
  - Response: busy=1 for exactly 4 cycles, then 0. Reads of addr 0..3 return 16'h0000 with rd_valid=1.
- Full and partial write:
  - Stimulus: write addr 2 = 16'hA55A with be=2'b11, then write 16'hFF00 with be=2'b01, then read addr 2.
  - Response: data_out=16'hA500, one cycle after the read request.
- Read latency and hold:
  - Stimulus: write addr1=16'h1234 and addr3=16'hBEEF, then read 1 and read 3 back-to-back, then idle for 3 cycles.
  - Response: data_out=16'h1234, then 16'hBEEF; rd_valid is high for 2 cycles; data_out holds 16'hBEEF afterwards.
- Out of range:
  - Stimulus: write addr 5 = 16'h7777, then read addr 5.
  - Response: err pulses on both accesses; the read gives data_out=0; a later sweep of addr 0..3 is unchanged.
- Runtime init:
  - Stimulus: fill all words with 16'hFFFF, pulse init, and assert en with a write during busy.
  - Response: busy for 4 cycles; the write is ignored; all words read 16'h0000.
- Reset mid-fill:
  - Stimulus: pulse init, and after 2 fill cycles assert clr=0 for 1 cycle.
  - Response: data_out=0; busy stays high for 4 further cycles; fill restarts at address 0.

Source files
------------

// File: rtl/ram_banked_be_if.sv
// Access bus of the banked byte-enable RAM: request/write side from the
// master, registered read data and status flags back from the RAM.
interface ram_banked_be_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2,
    parameter int ADDR_W = 3
);
    logic                     en;
    logic                     rw;
    logic [LANES-1:0]         be;
    logic [ADDR_W-1:0]        addr;
    logic [LANE_W*LANES-1:0]  data_in;
    logic                     init;
    logic [LANE_W*LANES-1:0]  data_out;
    logic                     rd_valid;
    logic                     busy;
    logic                     err;

    modport master (
        output en, rw, be, addr, data_in, init,
        input  data_out, rd_valid, busy, err
    );

    modport slave (
        input  en, rw, be, addr, data_in, init,
        output data_out, rd_valid, busy, err
    );
endinterface

// File: rtl/ram_banked_be.sv
// Single-port synchronous RAM of LANES x LANE_W lanes with per-lane write
// enables, registered read + valid strobe, zero-fill engine and
// out-of-range detection. Fill runs after reset and on init requests.
module ram_banked_be #(
    parameter int LANE_W = 8,
    parameter int LANES  = 2,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr,
    ram_banked_be_if.slave    bus
);
    localparam int DATA_W = LANE_W * LANES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range;
    logic                acc_wr;
    logic [IDX_W-1:0]    addr_idx;
    logic [IDX_W-1:0]    ptr_idx;

    // Address decode and qualified write strobe for the array.
    always_comb begin
        in_range = ({1'b0, bus.addr} < DEPTH_V);
        addr_idx = bus.addr[IDX_W-1:0];
        ptr_idx  = ptr[IDX_W-1:0];
        acc_wr   = (state == IDLE) && !bus.init && bus.en && bus.rw && in_range;
    end

    // Array storage: zero-fill writes while filling, lane-masked writes otherwise.
    always_ff @(posedge clk) begin
        if (clr) begin
            if (state == FILL) begin
                mem[ptr_idx] <= '0;
            end else if (acc_wr) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (bus.be[k]) begin
                        mem[addr_idx][k*LANE_W +: LANE_W] <= bus.data_in[k*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    // Control FSM with registered read data, strobes and busy flag.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state        <= FILL;
            ptr          <= '0;
            bus.busy     <= 1'b1;
            bus.data_out <= '0;
            bus.rd_valid <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    bus.rd_valid <= 1'b0;
                    bus.err      <= 1'b0;
                    if (ptr == LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    if (bus.init) begin
                        state        <= FILL;
                        ptr          <= '0;
                        bus.busy     <= 1'b1;
                        bus.rd_valid <= 1'b0;
                        bus.err      <= 1'b0;
                    end else if (bus.en) begin
                        bus.err      <= !in_range;
                        bus.rd_valid <= !bus.rw;
                        if (!bus.rw) begin
                            bus.data_out <= in_range ? mem[addr_idx] : '0;
                        end
                    end else begin
                        bus.rd_valid <= 1'b0;
                        bus.err      <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
